audio_dac_serializer: RTL and testbench
=======================================

# audio_dac_serializer

Parametrised stereo audio DAC serializer and the next generation of the sound generator's codec output stage. Samples arrive as left/right pairs over a valid/ready stream and are buffered in a small FIFO. The block generates its own bit clock and LR clock from the system clock, then shifts samples MSB-first to the WM8731 DAC in a run-time selectable I2S or left-justified format. Underruns are detected, flagged and replaced with silence.

## Interface
- `SAMPLE_W`, 16: bits per channel sample, two's complement.
- `SLOT_BITS`, 32: bit-clock periods per channel slot. Requires `SLOT_BITS >= SAMPLE_W + 1`.
- `BCLK_HALF`, 2: clk cycles per half bit-clock period, ≥1. Frame rate is clk / (4·`BCLK_HALF`·`SLOT_BITS`).
- `FIFO_DEPTH`, 8: sample-pair entries, power of two, ≥2.

Ports:
- `clk`  in  1  system clock; sole clock domain.
- `reset_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  run serializer; low holds the serial outputs idle.
- `mode`  in  1  0 = I2S, 1 = left-justified; latched only at frame start.
- `in_valid`  in  1  sample pair offered.
- `in_ready`  out  1  FIFO not full.
- `in_left`  in  `SAMPLE_W`  left sample.
- `in_right`  in  `SAMPLE_W`  right sample.
- `aud_bclk`  out  1  bit clock to the codec.
- `aud_daclrck`  out  1  DAC LR clock.
- `aud_dacdat`  out  1  serial data.
- `level`  out  clog2(`FIFO_DEPTH`)+1  FIFO occupancy.
- `underrun`  out  1  sticky; set when a frame starts with the FIFO empty.
- `underrun_clr`  in  1  clears `underrun`; a set in the same cycle wins.

## Operation
- Reset values:
  - `aud_bclk`=0, `aud_dacdat`=0, `underrun`=0, `level`=0, `in_ready`=1.
  - `aud_daclrck`=1, the I2S idle level; latched mode resets to I2S.
  - FIFO is emptied.
- Push: accepted when `in_valid & in_ready`. `in_ready` is derived from the registered count, so a push is refused while full even if a pop occurs in the same cycle.
- Pop: the FIFO is show-ahead, with the head pair visible combinationally. A pop happens only at frame start.
- Divider:
  - While `enable`=1, `div_cnt` counts 0..`BCLK_HALF`-1 and `aud_bclk` toggles on each wrap.
  - A falling event is a wrap while `aud_bclk`=1.
  - `bit_idx` counts 0..2·`SLOT_BITS`-1 on falling events and wraps.
- Frame start is the falling event at which `bit_idx` wraps to 0, or the first falling event after `enable` rises. At frame start:
  - latch `mode`;
  - if the FIFO is non-empty, pop the pair into the hold registers; otherwise load zeros and set `underrun`;
  - drive `aud_daclrck` to the left level: 0 in I2S, 1 in left-justified.
- Slot boundary (`bit_idx` = `SLOT_BITS`): `aud_daclrck` toggles to the right level.
- Data, with k = `bit_idx` mod `SLOT_BITS` and d = 1 for I2S, 0 for LJ:
  - `aud_dacdat` = sample bit [`SAMPLE_W`-1-(k-d)] for d ≤ k < `SAMPLE_W`+d;
  - `aud_dacdat` = 0 otherwise, including k=0 in I2S.
  - Left sample in slot 0, right sample in slot 1.
- `enable` falling:
  - synchronously clear `div_cnt` and `bit_idx`, `aud_bclk`=0, `aud_dacdat`=0;
  - `aud_daclrck` goes to the idle level = right level of the latched mode;
  - FIFO contents and `underrun` are kept.
- Reset mid-frame: every output takes its reset value immediately (asynchronous) and FIFO contents are lost.

## Timing
- All outputs are registered. `aud_daclrck`, `aud_dacdat` and `aud_bclk` falling change in the same clk cycle; the codec samples on `aud_bclk` rising.
- After `enable` rises: first `aud_bclk` rise at clk cycle `BCLK_HALF`; first falling event (frame start) at cycle 2·`BCLK_HALF`.
- `level` updates the cycle after a push or pop. A push and a pop in the same cycle leave `level` unchanged.
- Empty FIFO with push and frame start in the same cycle: underrun; the pushed pair is played next frame.
- Minimum push-to-output latency: the next frame start.

## Structure
- Package `audio_pkg`:
  - `audio_mode_t` enum (`MODE_I2S`, `MODE_LJ`);
  - function `lrck_left(mode)`;
  - `stereo_sample_t` struct parametrised by width via a typedef in the top.
- Sub-module `audio_sample_fifo`: show-ahead register FIFO with `level` and `full`/`empty`.
- Top holds the divider, bit counter and output mux.

## Test plan
- I2S, defaults, push L=16'h8001 R=16'h7FFE:
  - first frame shows `aud_daclrck`=0 for 32 bclk;
  - `aud_dacdat` is 0, then 1,0…0,1 (MSB at bclk 1), then 15 zeros;
  - right slot carries 0,0111…1110.
- LJ, same samples:
  - `aud_daclrck`=1 during left;
  - MSB on the first bclk of the slot; 16 zero bits of padding follow.
- Underrun: enable with the FIFO empty → `aud_dacdat` all 0 and `underrun`=1. Then `underrun_clr` → 0. Asserting `underrun_clr` at a frame start that is also empty keeps 1.
- Backpressure: push 9 pairs back-to-back → 8 accepted, `in_ready`=0, `level`=8. One frame later `level`=7 and `in_ready`=1.
- Mode change mid-frame: `mode` toggled at `bit_idx`=10 → current frame unchanged; the new format starts at the next frame.
- Reset at `bit_idx`=40 → all outputs at reset values within one cycle and `level`=0. `BCLK_HALF`=3 rerun confirms the bclk period is 6 clk.

Source files
------------

// File: rtl/audio_dac_serializer_pkg.sv
// Shared types for the stereo DAC serializer: output format enum and LR-clock helper.
// Latency: n/a (types and pure function only).
// Backpressure: n/a.
package audio_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } audio_mode_t;

  // LR clock level that marks the left slot: I2S uses low, left-justified uses high.
  // The idle / right-slot level is always the complement.
  function automatic logic lrck_left(input audio_mode_t m);
    return (m == MODE_LJ);
  endfunction

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Sample-pair input stream: in_valid/in_ready handshake carrying left/right samples.
// Latency: n/a (wires only).
// Backpressure: master holds the pair while in_valid & ~in_ready.
interface audio_dac_serializer_if #(
  parameter int SAMPLE_W = 16
);
  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_left;
  logic [SAMPLE_W-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/audio_dac_serializer_fifo.sv
// Show-ahead register FIFO of sample pairs; head entry visible combinationally.
// Latency: push visible at head and in level_o the cycle after acceptance.
// Backpressure: full_o from registered count; pushes while full and pops while empty are ignored.
// Ports: push_i/push_dat_i write side, pop_i/head_o read side, level_o/full_o/empty_o status.
module audio_sample_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [W-1:0]             push_dat_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] CNT_FULL = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// Stereo DAC serializer: buffers sample pairs, generates bclk/lrclk, shifts MSB-first in I2S or LJ.
// Latency: a pushed pair is played from the next frame start; all serial outputs are registered.
// Backpressure: in_ready = FIFO not full; an empty FIFO at frame start plays silence and flags underrun.
// Ports: clk/reset_n, enable, mode, in_bus (sample stream), aud_* codec pins, level, underrun/underrun_clr.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_BITS  = 32,
  parameter int BCLK_HALF  = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        mode,
  audio_dac_serializer_if.slave       in_bus,
  output logic                        aud_bclk,
  output logic                        aud_daclrck,
  output logic                        aud_dacdat,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        underrun,
  input  logic                        underrun_clr
);
  localparam int IDX_W = $clog2(2 * SLOT_BITS);
  localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * SLOT_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_SLOT = IDX_W'(SLOT_BITS);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  stereo_sample_t      push_pair, head_pair, hold_q, hold_d;
  logic                fifo_full, fifo_empty, push, pop, frame_start, wrap;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                bclk_q, bclk_d, lrck_q, lrck_d, dat_q, dat_d;
  logic                started_q, started_d, underrun_q, underrun_d;
  audio_mode_t         mode_q, mode_d;
  logic [SAMPLE_W-1:0] slot_sample;
  int                  slot_k;

  // Bit k of a slot: sample bit [SAMPLE_W-1-(k-d)] inside the data window, zero padding elsewhere.
  function automatic logic slot_bit(input logic [SAMPLE_W-1:0] s, input int k, input int d);
    logic [SAMPLE_W-1:0] t;
    slot_bit = 1'b0;
    t        = '0;
    if (k >= d && k < SAMPLE_W + d) begin
      t        = s << (k - d);
      slot_bit = t[SAMPLE_W-1];
    end
  endfunction

  assign push_pair       = {in_bus.in_left, in_bus.in_right};
  assign push            = in_bus.in_valid & ~fifo_full;
  assign in_bus.in_ready = ~fifo_full;
  assign pop             = frame_start & ~fifo_empty;

  audio_sample_fifo #(
    .W     (2 * SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push),
    .push_dat_i (push_pair),
    .pop_i      (pop),
    .head_o     (head_pair),
    .level_o    (level),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    div_d       = div_q;
    bclk_d      = bclk_q;
    idx_d       = idx_q;
    started_d   = started_q;
    mode_d      = mode_q;
    hold_d      = hold_q;
    lrck_d      = lrck_q;
    dat_d       = dat_q;
    underrun_d  = underrun_q;
    frame_start = 1'b0;
    wrap        = 1'b0;
    slot_k      = 0;
    slot_sample = '0;

    if (underrun_clr) underrun_d = 1'b0;

    if (!enable) begin
      // Idle: divider parked, lrclk rests at the right-slot level of the latched format.
      div_d     = '0;
      bclk_d    = 1'b0;
      idx_d     = '0;
      started_d = 1'b0;
      dat_d     = 1'b0;
      lrck_d    = ~lrck_left(mode_q);
    end else begin
      wrap  = (div_q == DIV_LAST);
      div_d = wrap ? '0 : div_q + 1'b1;
      if (wrap) begin
        bclk_d = ~bclk_q;
        if (bclk_q) begin
          // Falling bclk event: advance the frame position and present the next bit.
          started_d = 1'b1;
          if (!started_q || idx_q == IDX_LAST) begin
            idx_d       = '0;
            frame_start = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end

          if (frame_start) begin
            mode_d = audio_mode_t'(mode);
            if (fifo_empty) begin
              hold_d     = '0;
              underrun_d = 1'b1;  // set beats a simultaneous clear
            end else begin
              hold_d = head_pair;
            end
          end

          // The new frame's pair and mode feed the k=0 bit directly (LJ puts the MSB there).
          slot_k = int'(idx_d);
          if (idx_d >= IDX_SLOT) begin
            slot_k      = slot_k - SLOT_BITS;
            slot_sample = hold_d.right;
          end else begin
            slot_sample = hold_d.left;
          end
          lrck_d = (idx_d < IDX_SLOT) ? lrck_left(mode_d) : ~lrck_left(mode_d);
          dat_d  = slot_bit(slot_sample, slot_k, (mode_d == MODE_I2S) ? 1 : 0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q      <= '0;
      bclk_q     <= 1'b0;
      idx_q      <= '0;
      started_q  <= 1'b0;
      mode_q     <= MODE_I2S;
      hold_q     <= '0;
      lrck_q     <= 1'b1;
      dat_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      idx_q      <= idx_d;
      started_q  <= started_d;
      mode_q     <= mode_d;
      hold_q     <= hold_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      underrun_q <= underrun_d;
    end
  end

  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: table-driven frame vectors plus multi-cycle sequences.
// Serial bits are captured on every bclk rising edge into a ring buffer and compared as 64-bit frames.
// A second instance with BCLK_HALF=3 checks the divider timing.
module tb_audio_dac_serializer;

  logic       clk = 1'b0;
  logic       reset_n, enable, mode, underrun_clr, enable3;
  logic       aud_bclk, aud_daclrck, aud_dacdat, underrun;
  logic [3:0] level;
  logic       bclk3, lrck3, dat3, underrun3;
  logic [3:0] level3;

  int total  = 0;
  int passed = 0;

  localparam logic [63:0] LR_I2S = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] LR_LJ  = 64'hFFFF_FFFF_0000_0000;

  audio_dac_serializer_if #(.SAMPLE_W(16)) bus ();
  audio_dac_serializer_if #(.SAMPLE_W(16)) bus3 ();

  assign bus3.in_valid = 1'b0;
  assign bus3.in_left  = '0;
  assign bus3.in_right = '0;

  always #5 clk = ~clk;

  audio_dac_serializer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .mode         (mode),
    .in_bus       (bus),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  audio_dac_serializer #(.BCLK_HALF(3)) dut3 (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable3),
    .mode         (1'b0),
    .in_bus       (bus3),
    .aud_bclk     (bclk3),
    .aud_daclrck  (lrck3),
    .aud_dacdat   (dat3),
    .level        (level3),
    .underrun     (underrun3),
    .underrun_clr (1'b0)
  );

  // Capture data/lrclk as seen by the codec at each bclk rise.
  logic rec_dat  [1024];
  logic rec_lrck [1024];
  int   rise_cnt  = 0;
  logic bclk_prev = 1'b0;

  always @(negedge clk) begin
    if (aud_bclk === 1'b1 && bclk_prev === 1'b0) begin
      rec_dat[10'(rise_cnt)]  = aud_dacdat;
      rec_lrck[10'(rise_cnt)] = aud_daclrck;
      rise_cnt = rise_cnt + 1;
    end
    bclk_prev = aud_bclk;
  end

  // Rise 'base' precedes the first frame start; frame f bit b is rise base+1+64f+b.
  // Returned vector holds frame bit 0 in bit 63.
  function automatic logic [63:0] frame_dat(input int base, input int f);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 64; b++) v[63-b] = rec_dat[10'(base + 1 + 64 * f + b)];
    return v;
  endfunction

  function automatic logic [63:0] frame_lrck(input int base, input int f);
    logic [63:0] v;
    v = '0;
    for (int b = 0; b < 64; b++) v[63-b] = rec_lrck[10'(base + 1 + 64 * f + b)];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic wait_rises(input int base, input int n);
    int cyc;
    cyc = 0;
    while (rise_cnt < base + n && cyc < 20000) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (rise_cnt < base + n) begin
      total = total + 1;
      $display("FAIL rise timeout: got %0d rises, expected %0d", rise_cnt - base, n);
    end
  endtask

  task automatic wait_lrck(input logic v);
    int cyc;
    cyc = 0;
    while (aud_daclrck !== v && cyc < 1000) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (aud_daclrck !== v) begin
      total = total + 1;
      $display("FAIL lrck timeout: got %b, expected %b", aud_daclrck, v);
    end
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    enable       = 1'b0;
    underrun_clr = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
    bus.in_valid = 1'b1;
    bus.in_left  = l;
    bus.in_right = r;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  typedef struct {
    logic        md;
    logic [15:0] l;
    logic [15:0] r;
    logic [63:0] dat;
    logic [63:0] lr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int base, n, acc;

    vecs[0] = '{1'b0, 16'h8001, 16'h7FFE, 64'h4000_8000_3FFF_0000, LR_I2S};
    vecs[1] = '{1'b1, 16'h8001, 16'h7FFE, 64'h8001_0000_7FFE_0000, LR_LJ};
    vecs[2] = '{1'b0, 16'h1234, 16'hABCD, 64'h091A_0000_55E6_8000, LR_I2S};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0001, 64'hFFFF_0000_0001_0000, LR_LJ};
    vecs[4] = '{1'b0, 16'hFFFF, 16'h0001, 64'h7FFF_8000_0000_8000, LR_I2S};

    reset_n      = 1'b0;
    enable       = 1'b0;
    enable3      = 1'b0;
    mode         = 1'b0;
    underrun_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_left  = '0;
    bus.in_right = '0;
    @(posedge clk); #1;

    // Reset values
    chk("rst bclk", 64'(aud_bclk), 64'd0);
    chk("rst dacdat", 64'(aud_dacdat), 64'd0);
    chk("rst lrck", 64'(aud_daclrck), 64'd1);
    chk("rst underrun", 64'(underrun), 64'd0);
    chk("rst level", 64'(level), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);

    // Table-driven single-frame vectors
    for (int i = 0; i < 5; i++) begin
      do_reset();
      mode = vecs[i].md;
      push_pair(vecs[i].l, vecs[i].r);
      base   = rise_cnt;
      enable = 1'b1;
      wait_rises(base, 65);
      chk($sformatf("vec%0d dat", i), frame_dat(base, 0), vecs[i].dat);
      chk($sformatf("vec%0d lrck", i), frame_lrck(base, 0), vecs[i].lr);
      chk($sformatf("vec%0d underrun", i), 64'(underrun), 64'd0);
      enable = 1'b0;
    end

    // Enable latency: bclk rises BCLK_HALF cycles in, frame start at 2*BCLK_HALF
    do_reset();
    mode   = 1'b0;
    enable = 1'b1;
    n = 0;
    while (aud_bclk !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("first bclk rise cycle", 64'(n), 64'd2);
    while (aud_daclrck !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
    chk("first frame start cycle", 64'(n), 64'd4);
    enable = 1'b0;

    // Underrun: silence, sticky flag, clear, and set-beats-clear at an empty frame start
    do_reset();
    mode   = 1'b0;
    base   = rise_cnt;
    enable = 1'b1;
    wait_rises(base, 65);
    chk("underrun silent dat", frame_dat(base, 0), 64'd0);
    chk("underrun lrck", frame_lrck(base, 0), LR_I2S);
    chk("underrun set", 64'(underrun), 64'd1);
    wait_lrck(1'b0);
    wait_lrck(1'b1);
    underrun_clr = 1'b1;
    @(posedge clk); #1;
    underrun_clr = 1'b0;
    chk("underrun cleared", 64'(underrun), 64'd0);
    underrun_clr = 1'b1;
    wait_lrck(1'b0);
    chk("underrun set wins", 64'(underrun), 64'd1);
    underrun_clr = 1'b0;
    @(negedge clk); #1;
    chk("underrun kept", 64'(underrun), 64'd1);
    enable = 1'b0;

    // Backpressure: 9 back-to-back offers into an 8-deep FIFO, then drain order
    do_reset();
    mode = 1'b1;
    acc  = 0;
    for (int i = 0; i < 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_left  = 16'h1000 + 16'(i);
      bus.in_right = 16'h2000 + 16'(i);
      if (bus.in_ready === 1'b1) acc++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("bp accepted", 64'(acc), 64'd8);
    chk("bp in_ready full", 64'(bus.in_ready), 64'd0);
    chk("bp level full", 64'(level), 64'd8);
    base   = rise_cnt;
    enable = 1'b1;
    wait_rises(base, 2);
    chk("bp level after pop", 64'(level), 64'd7);
    chk("bp in_ready after pop", 64'(bus.in_ready), 64'd1);
    wait_rises(base, 129);
    chk("bp level after 2 pops", 64'(level), 64'd6);
    chk("bp frame0", frame_dat(base, 0), 64'h1000_0000_2000_0000);
    chk("bp frame1", frame_dat(base, 1), 64'h1001_0000_2001_0000);
    enable = 1'b0;

    // Mode toggled at bit_idx 10: current frame stays I2S, next frame is LJ
    do_reset();
    mode = 1'b0;
    push_pair(16'h8001, 16'h7FFE);
    push_pair(16'h8001, 16'h7FFE);
    base   = rise_cnt;
    enable = 1'b1;
    wait_rises(base, 12);
    mode = 1'b1;
    wait_rises(base, 129);
    chk("mode f0 dat", frame_dat(base, 0), 64'h4000_8000_3FFF_0000);
    chk("mode f0 lrck", frame_lrck(base, 0), LR_I2S);
    chk("mode f1 dat", frame_dat(base, 1), 64'h8001_0000_7FFE_0000);
    chk("mode f1 lrck", frame_lrck(base, 1), LR_LJ);
    enable = 1'b0;

    // Asynchronous reset at bit_idx 40 (LJ, right slot, R bit 7 on the line)
    do_reset();
    mode = 1'b1;
    push_pair(16'h0000, 16'h00FF);
    push_pair(16'h1111, 16'h2222);
    push_pair(16'h3333, 16'h4444);
    base   = rise_cnt;
    enable = 1'b1;
    wait_rises(base, 42);
    chk("pre-rst level", 64'(level), 64'd2);
    chk("pre-rst lrck", 64'(aud_daclrck), 64'd0);
    chk("pre-rst dacdat", 64'(aud_dacdat), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid-rst bclk", 64'(aud_bclk), 64'd0);
    chk("mid-rst dacdat", 64'(aud_dacdat), 64'd0);
    chk("mid-rst lrck", 64'(aud_daclrck), 64'd1);
    chk("mid-rst underrun", 64'(underrun), 64'd0);
    chk("mid-rst level", 64'(level), 64'd0);
    chk("mid-rst in_ready", 64'(bus.in_ready), 64'd1);
    do_reset();

    // BCLK_HALF=3 instance: first rise after 3 cycles, 6-cycle bclk period
    enable3 = 1'b1;
    n = 0;
    while (bclk3 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("bclk3 first rise", 64'(n), 64'd3);
    n = 0;
    while (bclk3 !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
    while (bclk3 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    chk("bclk3 period", 64'(n), 64'd6);
    enable3 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
